// File: rtl/pc_pkg.sv
// Shared types and increment constants for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_state_t;

    localparam int unsigned PC_INC_W = 4;
    localparam int unsigned PC_INC_C = 2;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: trap > branch > sequential > hold, with target alignment and misalign flag.
// PC_COMPRESSED_EN selects halfword alignment and a 2/4-byte increment; otherwise word-only.
module pc_next_sel #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  redirect_en_i,
    input  logic                  seq_en_i,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_vector_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic                  instr_is_c_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic [DATA_WIDTH-1:0] pc_next_o,
    output logic                  redirect_o,
    output logic                  misaligned_o
);
    import pc_pkg::*;

`ifdef PC_COMPRESSED_EN
    localparam int unsigned Align = 1;

    logic [DATA_WIDTH-1:0] inc;
    assign inc = instr_is_c_i ? DATA_WIDTH'(PC_INC_C) : DATA_WIDTH'(PC_INC_W);
`else
    localparam int unsigned Align = 2;

    logic [DATA_WIDTH-1:0] inc;
    logic                  unused_instr_is_c;
    assign inc               = DATA_WIDTH'(PC_INC_W);
    assign unused_instr_is_c = instr_is_c_i;
`endif

    logic [DATA_WIDTH-1:0] target;

    always_comb begin
        target     = branch_target_i;
        redirect_o = 1'b0;
        if (redirect_en_i && trap_i) begin
            target     = trap_vector_i;
            redirect_o = 1'b1;
        end else if (redirect_en_i && branch_taken_i) begin
            redirect_o = 1'b1;
        end

        misaligned_o = redirect_o && (|target[Align-1:0]);

        // Sequential wrap modulo 2^DATA_WIDTH falls out of the truncating add.
        if (redirect_o) begin
            pc_next_o = {target[DATA_WIDTH-1:Align], {Align{1'b0}}};
        end else if (seq_en_i) begin
            pc_next_o = pc_i + inc;
        end else begin
            pc_next_o = pc_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: boot delay, handshaked sequential fetch, redirects, debug halt.
// Alignment and increment width follow PC_COMPRESSED_EN (see pc_next_sel).
module pc_unit #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h3000_0000,
    parameter int unsigned           BOOT_DELAY   = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_stall,
    input  logic                  i_fetch_ready,
    input  logic                  i_branch_taken,
    input  logic [DATA_WIDTH-1:0] i_branch_target,
    input  logic                  i_trap,
    input  logic [DATA_WIDTH-1:0] i_trap_vector,
    input  logic                  i_halt_req,
    input  logic                  i_resume,
    input  logic                  i_instr_is_c,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic                  o_fetch_valid,
    output logic                  o_redirect,
    output logic                  o_misaligned,
    output logic                  o_halted
);
    import pc_pkg::*;

    localparam int unsigned       CntW    = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [CntW-1:0]   LastCnt = (BOOT_DELAY == 0) ? '0 : CntW'(BOOT_DELAY - 1);

    pc_state_t             state_q, state_d;
    logic [CntW-1:0]       boot_cnt_q, boot_cnt_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  redirect_q, redirect_d;
    logic                  misaligned_q, misaligned_d;

    logic                  boot_done;
    logic                  fetch_valid;
    logic                  halted;
    logic                  redirect_en;
    logic                  seq_en;

    assign boot_done = (BOOT_DELAY == 0) || (boot_cnt_q == LastCnt);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: if (boot_done) state_d = RUN;
            RUN:  if (i_halt_req && (!fetch_valid || i_fetch_ready)) state_d = HALT;
            HALT: if (i_resume) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = 1'b0;
        halted      = 1'b0;
        redirect_en = 1'b0;
        unique case (state_q)
            BOOT: ;
            RUN: begin
                fetch_valid = 1'b1;
                redirect_en = 1'b1;
            end
            HALT: begin
                halted      = 1'b1;
                redirect_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign seq_en     = (state_q == RUN) && fetch_valid && i_fetch_ready && !i_stall;
    assign boot_cnt_d = ((state_q == BOOT) && !boot_done) ? boot_cnt_q + CntW'(1) : boot_cnt_q;

    pc_next_sel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next_sel (
        .redirect_en_i   (redirect_en),
        .seq_en_i        (seq_en),
        .trap_i          (i_trap),
        .trap_vector_i   (i_trap_vector),
        .branch_taken_i  (i_branch_taken),
        .branch_target_i (i_branch_target),
        .instr_is_c_i    (i_instr_is_c),
        .pc_i            (pc_q),
        .pc_next_o       (pc_d),
        .redirect_o      (redirect_d),
        .misaligned_o    (misaligned_d)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pc_q         <= RESET_VECTOR;
            boot_cnt_q   <= '0;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            boot_cnt_q   <= boot_cnt_d;
            redirect_q   <= redirect_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_fetch_valid = fetch_valid;
    assign o_redirect    = redirect_q;
    assign o_misaligned  = misaligned_q;
    assign o_halted      = halted;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model pushes expected outputs per edge.
module tb_pc_unit;

    localparam int unsigned BootDelay = 4;
    localparam logic [31:0] ResetVec  = 32'h3000_0000;
`ifdef PC_COMPRESSED_EN
    localparam logic [31:0] AlignMask = 32'h1;
    localparam logic [31:0] ExpMisPc  = 32'h3000_0042;
    localparam logic [31:0] ExpMisBit = 32'h0;
`else
    localparam logic [31:0] AlignMask = 32'h3;
    localparam logic [31:0] ExpMisPc  = 32'h3000_0040;
    localparam logic [31:0] ExpMisBit = 32'h1;
`endif

    logic        clk = 1'b0;
    logic        arst;
    logic        i_stall, i_fetch_ready, i_branch_taken, i_trap;
    logic        i_halt_req, i_resume, i_instr_is_c;
    logic [31:0] i_branch_target, i_trap_vector;
    logic [31:0] o_pc;
    logic        o_fetch_valid, o_redirect, o_misaligned, o_halted;

    always #5 clk = ~clk;

    pc_unit #(
        .DATA_WIDTH   (32),
        .RESET_VECTOR (ResetVec),
        .BOOT_DELAY   (BootDelay)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .i_stall         (i_stall),
        .i_fetch_ready   (i_fetch_ready),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_trap          (i_trap),
        .i_trap_vector   (i_trap_vector),
        .i_halt_req      (i_halt_req),
        .i_resume        (i_resume),
        .i_instr_is_c    (i_instr_is_c),
        .o_pc            (o_pc),
        .o_fetch_valid   (o_fetch_valid),
        .o_redirect      (o_redirect),
        .o_misaligned    (o_misaligned),
        .o_halted        (o_halted)
    );

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        redirect;
        logic        misaligned;
        logic        halted;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Model state: 0 boot, 1 run, 2 halt.
    int          m_state;
    int          m_cnt;
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_pc    = ResetVec;
    endtask

    task automatic model_edge(output exp_t e);
        int          nst;
        logic [31:0] npc, tgt, inc;
        logic        red, mis;
        nst = m_state;
        npc = m_pc;
        red = 1'b0;
        mis = 1'b0;
        inc = 32'd4;
`ifdef PC_COMPRESSED_EN
        if (i_instr_is_c) inc = 32'd2;
`endif
        if (m_state == 0) begin
            if (m_cnt + 1 >= int'(BootDelay)) nst = 1;
            m_cnt++;
        end else begin
            if (i_trap || i_branch_taken) begin
                tgt = i_trap ? i_trap_vector : i_branch_target;
                red = 1'b1;
                mis = (tgt & AlignMask) != 0;
                npc = tgt & ~AlignMask;
            end else if (m_state == 1 && i_fetch_ready && !i_stall) begin
                npc = m_pc + inc;
            end
            if (m_state == 1 && i_halt_req && i_fetch_ready) nst = 2;
            if (m_state == 2 && i_resume) nst = 1;
        end
        m_state      = nst;
        m_pc         = npc;
        e.pc         = npc;
        e.valid      = (nst == 1);
        e.redirect   = red;
        e.misaligned = mis;
        e.halted     = (nst == 2);
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb_q.pop_front();
        check("pc", o_pc, e.pc);
        check("fetch_valid", 32'(o_fetch_valid), 32'(e.valid));
        check("redirect", 32'(o_redirect), 32'(e.redirect));
        check("misaligned", 32'(o_misaligned), 32'(e.misaligned));
        check("halted", 32'(o_halted), 32'(e.halted));
    endtask

    task automatic step();
        exp_t e;
        model_edge(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic idle_inputs();
        i_stall         = 1'b0;
        i_fetch_ready   = 1'b0;
        i_branch_taken  = 1'b0;
        i_branch_target = '0;
        i_trap          = 1'b0;
        i_trap_vector   = '0;
        i_halt_req      = 1'b0;
        i_resume        = 1'b0;
        i_instr_is_c    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, o_pc, ResetVec);
        check({tag, "_valid"}, 32'(o_fetch_valid), 32'd0);
        check({tag, "_redirect"}, 32'(o_redirect), 32'd0);
        check({tag, "_misaligned"}, 32'(o_misaligned), 32'd0);
        check({tag, "_halted"}, 32'(o_halted), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        arst = 1'b1;
        model_reset();
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        arst = 1'b0;

        // Boot delay: valid low for BootDelay edges, redirects ignored.
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h1234_5678;
        repeat (BootDelay - 1) step();
        check("boot_valid_low", 32'(o_fetch_valid), 32'd0);
        i_branch_taken = 1'b0;
        step();
        check("boot_valid_high", 32'(o_fetch_valid), 32'd1);
        check("boot_pc", o_pc, ResetVec);

        // Sequential fetch, then hold without ready.
        i_fetch_ready = 1'b1;
        step();
        check("seq_pc1", o_pc, 32'h3000_0004);
        step();
        check("seq_pc2", o_pc, 32'h3000_0008);
        i_fetch_ready = 1'b0;
        step();
        check("seq_hold", o_pc, 32'h3000_0008);

        // Trap beats branch, and stall does not block the redirect.
        i_stall         = 1'b1;
        i_trap          = 1'b1;
        i_trap_vector   = 32'h0000_0100;
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h3000_0040;
        step();
        check("trap_pc", o_pc, 32'h0000_0100);
        check("trap_redirect", 32'(o_redirect), 32'd1);
        idle_inputs();
        step();

        // Misaligned branch target.
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h3000_0042;
        step();
        check("mis_pc", o_pc, ExpMisPc);
        check("mis_flag", 32'(o_misaligned), ExpMisBit);
        i_branch_taken = 1'b0;
        step();

        // Halt waits for the pending fetch to be accepted.
        i_halt_req = 1'b1;
        step();
        check("halt_pending", 32'(o_halted), 32'd0);
        i_fetch_ready = 1'b1;
        step();
        check("halt_entered", 32'(o_halted), 32'd1);
        i_fetch_ready   = 1'b0;
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h3000_0080;
        step();
        check("halt_branch_pc", o_pc, 32'h3000_0080);
        i_branch_taken = 1'b0;
        i_halt_req     = 1'b0;
        i_resume       = 1'b1;
        step();
        check("resume_valid", 32'(o_fetch_valid), 32'd1);
        i_resume = 1'b0;

        // Sequential wrap at the top of the address space.
        i_branch_taken  = 1'b1;
        i_branch_target = 32'hFFFF_FFFC;
        step();
        i_branch_taken = 1'b0;
        i_fetch_ready  = 1'b1;
        step();
        check("wrap_pc", o_pc, 32'h0000_0000);

        // Random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            i_stall         = ($urandom % 4) == 0;
            i_fetch_ready   = ($urandom % 3) != 0;
            i_trap          = ($urandom % 10) == 0;
            i_trap_vector   = $urandom;
            i_branch_taken  = ($urandom % 6) == 0;
            i_branch_target = $urandom;
            i_halt_req      = ($urandom % 8) == 0;
            i_resume        = ($urandom % 4) == 0;
            i_instr_is_c    = 1'($urandom);
            step();
        end

        // Asynchronous reset in the middle of a fetch with a redirect pending.
        idle_inputs();
        i_resume        = 1'b1;
        step();
        i_resume        = 1'b0;
        i_fetch_ready   = 1'b1;
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h0000_4000;
        step();
        #2;
        arst = 1'b1;
        #1;
        check_reset_outputs("arst_mid");
        model_reset();
        @(negedge clk);
        arst = 1'b0;
        repeat (BootDelay + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
